// File: rtl/sha256_job_scheduler_if.sv
// rtl/sha256_job_scheduler_if.sv - job submission and completion handshake bundle
//
// Ports (as seen by the scheduler through the slave modport):
//   job_valid/job_ready       job offer handshake
//   job_msg_addr/job_out_addr message and hash output base addresses of the job
//   cmpl_valid/cmpl_ready     completion handshake
//   cmpl_core_id              core that finished the job
//   cmpl_out_addr             output address of the finished job
interface sha256_job_scheduler_if #(
    parameter int AW = 16
);
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_msg_addr;
    logic [AW-1:0] job_out_addr;
    logic          cmpl_valid;
    logic          cmpl_ready;
    logic [2:0]    cmpl_core_id;
    logic [AW-1:0] cmpl_out_addr;

    // Job producer / completion consumer side
    modport master (
        output job_valid, job_msg_addr, job_out_addr, cmpl_ready,
        input  job_ready, cmpl_valid, cmpl_core_id, cmpl_out_addr
    );

    // Scheduler side
    modport slave (
        input  job_valid, job_msg_addr, job_out_addr, cmpl_ready,
        output job_ready, cmpl_valid, cmpl_core_id, cmpl_out_addr
    );
endinterface

// File: rtl/sha256_job_scheduler.sv
// rtl/sha256_job_scheduler.sv - dispatches hash jobs to a bank of SHA-256 cores and reports completions
//
// Ports:
//   clk, reset_n    clock; asynchronous active-low reset (cores share this reset)
//   bus             job input and completion output handshakes (slave modport)
//   core_start      per-core one-cycle start pulse
//   core_msg_addr   per-core message address, core i at [i*AW +: AW]
//   core_out_addr   per-core output address, packed the same way
//   core_done       per-core done level, high while the core is idle
//   queue_count     jobs waiting in the FIFO
//   busy_cores      bit i set while core i is not FREE
module sha256_job_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sha256_job_scheduler_if.slave   bus,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES*AW-1:0] core_msg_addr,
    output logic [NUM_CORES*AW-1:0] core_out_addr,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic [3:0]              queue_count,
    output logic [NUM_CORES-1:0]    busy_cores
);

    localparam int PW  = $clog2(NUM_CORES);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;

    typedef enum logic [2:0] {
        C_FREE,
        C_START,
        C_WAIT_BUSY,
        C_RUN,
        C_REPORT
    } core_state_t;

    // Round-robin pick: scans from ptr upward with wrap; returns {found, index}.
    // Walking k downward lets the candidate closest to ptr overwrite the others.
    function automatic logic [PW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                            input logic [PW-1:0]        ptr);
        logic [PW:0]   r;
        logic [PW-1:0] c;
        r = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            c = PW'((int'(ptr) + k) % NUM_CORES);
            if (req[c]) begin
                r = {1'b1, c};
            end
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_CORES - 1)) ? '0 : idx + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Job FIFO
    // ------------------------------------------------------------------
    logic [AW-1:0]  fifo_msg [FIFO_DEPTH];
    logic [AW-1:0]  fifo_out [FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           fifo_nonempty;

    // job_ready comes from the registered count only, so a full FIFO refuses
    // a push even in a cycle where a dispatch frees an entry.
    assign bus.job_ready  = (count != CW'(FIFO_DEPTH));
    assign push           = bus.job_valid && bus.job_ready;
    assign fifo_nonempty  = (count != '0);
    assign queue_count    = 4'(count);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FAW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FAW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_msg[wr_ptr] <= bus.job_msg_addr;
            fifo_out[wr_ptr] <= bus.job_out_addr;
        end
    end

    // ------------------------------------------------------------------
    // Dispatch selection
    // ------------------------------------------------------------------
    core_state_t          state_q [NUM_CORES];
    core_state_t          state_d [NUM_CORES];
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] reporting;
    logic [PW-1:0]        dispatch_ptr;
    logic [PW-1:0]        disp_idx;
    logic                 disp_found;
    logic                 dispatch_en;

    // A core is only eligible when both our view (FREE) and the core itself
    // (done high, i.e. idle) agree it can take work.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i]  = (state_q[i] == C_FREE) && core_done[i];
            reporting[i] = (state_q[i] == C_REPORT);
        end
    end

    assign {disp_found, disp_idx} = rr_pick(eligible, dispatch_ptr);
    assign dispatch_en            = disp_found && fifo_nonempty;
    assign pop                    = dispatch_en;

    // Addresses are captured at dispatch and held until the core's next
    // dispatch, so they are valid during the start pulse and for reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_msg_addr <= '0;
            core_out_addr <= '0;
            dispatch_ptr  <= '0;
        end else if (dispatch_en) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (disp_idx == PW'(i)) begin
                    core_msg_addr[i*AW +: AW] <= fifo_msg[rd_ptr];
                    core_out_addr[i*AW +: AW] <= fifo_out[rd_ptr];
                end
            end
            dispatch_ptr <= ptr_after(disp_idx);
        end
    end

    // ------------------------------------------------------------------
    // Completion reporting
    // ------------------------------------------------------------------
    logic          cmpl_valid_q;
    logic [PW-1:0] cmpl_idx_q;
    logic [AW-1:0] cmpl_out_addr_q;
    logic [PW-1:0] cmpl_ptr;
    logic [PW-1:0] cmpl_sel;
    logic          cmpl_found;
    logic          cmpl_fire;

    assign {cmpl_found, cmpl_sel} = rr_pick(reporting, cmpl_ptr);
    assign cmpl_fire              = cmpl_valid_q && bus.cmpl_ready;

    assign bus.cmpl_valid    = cmpl_valid_q;
    assign bus.cmpl_core_id  = 3'(cmpl_idx_q);
    assign bus.cmpl_out_addr = cmpl_out_addr_q;

    // A new selection is only loaded while cmpl_valid is low, which keeps the
    // outputs frozen during backpressure and leaves a gap cycle after each
    // handshake so the accepted core has already left REPORT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmpl_valid_q    <= 1'b0;
            cmpl_idx_q      <= '0;
            cmpl_out_addr_q <= '0;
            cmpl_ptr        <= '0;
        end else if (cmpl_fire) begin
            cmpl_valid_q <= 1'b0;
            cmpl_ptr     <= ptr_after(cmpl_idx_q);
        end else if (!cmpl_valid_q && cmpl_found) begin
            cmpl_valid_q <= 1'b1;
            cmpl_idx_q   <= cmpl_sel;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (cmpl_sel == PW'(i)) begin
                    cmpl_out_addr_q <= core_out_addr[i*AW +: AW];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-core tracking FSMs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i] <= C_FREE;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // WAIT_BUSY exists because done is still high from the previous idle
    // period right after start; completion is only believed after done has
    // been seen low and then high again.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            state_d[i]    = state_q[i];
            core_start[i] = 1'b0;
            busy_cores[i] = (state_q[i] != C_FREE);
            case (state_q[i])
                C_FREE: begin
                    if (dispatch_en && (disp_idx == PW'(i))) begin
                        state_d[i] = C_START;
                    end
                end
                C_START: begin
                    core_start[i] = 1'b1;
                    state_d[i]    = C_WAIT_BUSY;
                end
                C_WAIT_BUSY: begin
                    if (!core_done[i]) begin
                        state_d[i] = C_RUN;
                    end
                end
                C_RUN: begin
                    if (core_done[i]) begin
                        state_d[i] = C_REPORT;
                    end
                end
                C_REPORT: begin
                    if (cmpl_fire && (cmpl_idx_q == PW'(i))) begin
                        state_d[i] = C_FREE;
                    end
                end
                default: begin
                    state_d[i] = C_FREE;
                end
            endcase
        end
    end

endmodule
